axis32_to_ad936x_tx: RTL and testbench



---
 rtl/axis32_to_ad936x_tx.sv | 122 ++++++++++++
 tb/tb_axis32_to_ad936x_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis32_to_ad936x_tx.sv
// axis32_to_ad936x_tx: AXI4-Stream {I,Q} words to AD936x CMOS DDR transmit halves.
// Buffers the stream in a FIFO and plays it out one word per clock. Until enough
// data has been buffered, or when the buffer runs dry, it sends zero samples.
// Optional macro AXIS32_TX_SAT_EN: saturate each 16-bit component to 12 bits
// instead of truncating it.
// Ports:
//   tx_clk_in, tx_resetn      : data clock, asynchronous active-low reset
//   tx_enable                 : stream enable
//   s_axis_t*                 : 32-bit AXIS input, [31:16]=I, [15:0]=Q (tkeep/tlast ignored)
//   tx_d_pos / tx_d_neg       : 12-bit I / Q for the rising / falling ODDR half
//   tx_f_pos / tx_f_neg       : constant FRAME pattern 0 / 1
//   tx_active, underflow_cnt  : RUN indicator, saturating underflow event count
module axis32_to_ad936x_tx #(
    parameter int FIFO_DEPTH    = 16,
    parameter int PREFILL_LEVEL = 8
) (
    input  logic        tx_clk_in,
    input  logic        tx_resetn,
    input  logic        tx_enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    output logic [11:0] tx_d_pos,
    output logic [11:0] tx_d_neg,
    output logic        tx_f_pos,
    output logic        tx_f_neg,
    output logic        tx_active,
    output logic [15:0] underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_PRE  = (AW+1)'(PREFILL_LEVEL);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_RUN} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_level;
    logic          r_ready, r_active;
    logic [11:0]   r_d_pos, r_d_neg;
    logic [15:0]   r_uf_cnt;
    logic          w_wr, w_pop, w_uf, w_empty;
    logic [31:0]   w_rd;
    logic [11:0]   w_i, w_q;
    logic          w_unused;

    assign w_unused = &{1'b0, s_axis_tkeep, s_axis_tlast};

    // r_ready keeps tready low while reset is held, independent of the level
    assign s_axis_tready = r_ready && (r_level != LVL_FULL);
    assign w_wr          = s_axis_tvalid && s_axis_tready;
    assign w_empty       = (r_level == '0);
    assign w_rd          = r_mem[r_rptr];

`ifdef AXIS32_TX_SAT_EN
    function automatic logic [11:0] f_sat(input logic signed [15:0] x);
        f_sat = (x > 16'sd2047) ? 12'h7FF : (x < -16'sd2048) ? 12'h800 : x[11:0];
    endfunction
    assign w_i = f_sat(w_rd[31:16]);
    assign w_q = f_sat(w_rd[15:0]);
`else
    logic w_unused_trunc;
    assign w_unused_trunc = ^{w_rd[31:28], w_rd[15:12]};
    assign w_i = w_rd[27:16];
    assign w_q = w_rd[11:0];
`endif

    // Enable drop wins over underflow; an empty RUN slot is the only underflow event
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_uf   = 1'b0;
        case (r_state)
            S_IDLE:    w_next = tx_enable ? S_PREFILL : S_IDLE;
            S_PREFILL: w_next = !tx_enable ? S_IDLE : (r_level >= LVL_PRE) ? S_RUN : S_PREFILL;
            S_RUN: begin
                w_pop  = tx_enable && !w_empty;
                w_uf   = tx_enable && w_empty;
                w_next = !tx_enable ? S_IDLE : w_empty ? S_PREFILL : S_RUN;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk_in) begin
        if (w_wr) r_mem[r_wptr] <= s_axis_tdata;
    end

    always_ff @(posedge tx_clk_in or negedge tx_resetn) begin
        if (!tx_resetn) begin
            r_state  <= S_IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
            r_active <= 1'b0;
            r_d_pos  <= '0;
            r_d_neg  <= '0;
            r_uf_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_ready  <= 1'b1;
            r_active <= (w_next == S_RUN);
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level  <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_d_pos  <= w_pop ? w_i : 12'h000;
            r_d_neg  <= w_pop ? w_q : 12'h000;
            if (w_uf && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    assign tx_d_pos      = r_d_pos;
    assign tx_d_neg      = r_d_neg;
    assign tx_f_pos      = 1'b0;
    assign tx_f_neg      = 1'b1;
    assign tx_active     = r_active;
    assign underflow_cnt = r_uf_cnt;
endmodule

// File: tb/tb_axis32_to_ad936x_tx.sv
// tb_axis32_to_ad936x_tx: scoreboard bench for the AXIS to AD936x transmit converter.
module tb_axis32_to_ad936x_tx;
    logic        tx_clk_in = 1'b0;
    logic        tx_resetn = 1'b0;
    logic        tx_enable = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tlast = 1'b0;
    logic [11:0] tx_d_pos, tx_d_neg;
    logic        tx_f_pos, tx_f_neg, tx_active;
    logic [15:0] underflow_cnt;

    axis32_to_ad936x_tx #(.FIFO_DEPTH(16), .PREFILL_LEVEL(8)) dut (
        .tx_clk_in(tx_clk_in), .tx_resetn(tx_resetn), .tx_enable(tx_enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .tx_d_pos(tx_d_pos), .tx_d_neg(tx_d_neg), .tx_f_pos(tx_f_pos), .tx_f_neg(tx_f_neg),
        .tx_active(tx_active), .underflow_cnt(underflow_cnt)
    );

    always #5 tx_clk_in = ~tx_clk_in;

    int          n_chk = 0, n_pass = 0, n_out = 0, n_acc = 0;
    bit          mon_en = 1'b1, hold = 1'b0;
    logic [31:0] cur_w = '0;
    logic [23:0] exp_q[$];

    // Reference conversion: signed value, optionally clamped, reduced modulo 4096
    function automatic logic [11:0] exp12(input logic [15:0] x);
        int v = int'($signed(x));
`ifdef AXIS32_TX_SAT_EN
        if (v > 2047) v = 2047;
        else if (v < -2048) v = -2048;
`endif
        return 12'(v & 4095);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; the accepted word's expected output goes to the scoreboard
    task automatic drive(input bit v, input bit fix = 1'b0, input logic [31:0] w = '0);
        @(negedge tx_clk_in);
        if (!hold) begin
            if (fix) cur_w = w;
            else begin
                cur_w = $urandom;
                if (exp12(cur_w[31:16]) == 0 && exp12(cur_w[15:0]) == 0) cur_w[15:0] = 16'h0001;
            end
        end
        s_axis_tdata  = cur_w;
        s_axis_tvalid = v;
        s_axis_tkeep  = 4'($urandom);
        s_axis_tlast  = 1'($urandom);
        hold = v && !s_axis_tready;
        if (v && s_axis_tready) begin
            exp_q.push_back({exp12(cur_w[31:16]), exp12(cur_w[15:0])});
            n_acc++;
        end
    endtask

    task automatic wait_active(input bit val, input int max, input string name);
        int n = 0;
        do begin
            drive(1'b0);
            n++;
        end while (tx_active !== val && n < max);
        chk(name, 32'(tx_active), 32'(val));
    endtask

    // Monitor: every non-zero sample pair is a popped word and must match the queue head
    always @(negedge tx_clk_in) begin
        if (mon_en && tx_resetn && (tx_d_pos != 0 || tx_d_neg != 0)) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected_out", 32'({tx_d_pos, tx_d_neg}), 32'h0);
            else chk("data", 32'({tx_d_pos, tx_d_neg}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap0, snap1;
        #3;
        chk("rst_tready", 32'(s_axis_tready), 32'h0);
        chk("rst_d", 32'({tx_d_pos, tx_d_neg}), 32'h0);
        chk("rst_frame", 32'({tx_f_pos, tx_f_neg}), 32'h1);
        chk("rst_active", 32'(tx_active), 32'h0);
        chk("rst_uf", 32'(underflow_cnt), 32'h0);
        @(negedge tx_clk_in);
        tx_resetn = 1'b1;
        drive(1'b0);
        chk("tready_after_rst", 32'(s_axis_tready), 32'h1);

        tx_enable = 1'b1;
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, {16'h0001 + 16'(k), 16'hFFFF - 16'(k)});
        drive(1'b1);
        chk("active_before_prefill", 32'(tx_active), 32'h0);
        drive(1'b1);
        chk("active_after_prefill", 32'(tx_active), 32'h1);
        drive(1'b1);
        drive(1'b1);
        #1 snap0 = n_out;
        for (int k = 0; k < 28; k++) drive(1'b1);
        #1 snap1 = n_out;
        chk("no_gaps", 32'(snap1 - snap0), 32'd28);
        chk("uf_steady", 32'(underflow_cnt), 32'h0);
        chk("frame_run", 32'({tx_f_pos, tx_f_neg}), 32'h1);

        wait_active(1'b0, 40, "drain1_active");
        chk("uf1", 32'(underflow_cnt), 32'd1);
        chk("uf1_zero", 32'({tx_d_pos, tx_d_neg}), 32'h0);
        chk("drain1_empty", 32'(exp_q.size()), 32'h0);
        for (int k = 0; k < 8; k++) drive(1'b1);
        wait_active(1'b1, 10, "resume_active");
        wait_active(1'b0, 40, "drain2_active");
        chk("uf2", 32'(underflow_cnt), 32'd2);
        chk("drain2_empty", 32'(exp_q.size()), 32'h0);

        tx_enable = 1'b0;
        for (int k = 0; k < 12; k++) drive(1'b1);
        tx_enable = 1'b1;
        wait_active(1'b1, 5, "en_run");
        drive(1'b0);
        drive(1'b0);
        tx_enable = 1'b0;
        drive(1'b0);
        chk("en_drop_active", 32'(tx_active), 32'h0);
        for (int k = 0; k < 3; k++) drive(1'b0);
        chk("en_drop_zero", 32'({tx_d_pos, tx_d_neg}), 32'h0);
        chk("en_drop_uf", 32'(underflow_cnt), 32'd2);
        chk("en_drop_level", 32'(exp_q.size()), 32'd10);
        tx_enable = 1'b1;
        drive(1'b0);
        drive(1'b0);
        chk("reenable_active", 32'(tx_active), 32'h1);
        wait_active(1'b0, 40, "drain3_active");
        chk("uf3", 32'(underflow_cnt), 32'd3);
        chk("drain3_empty", 32'(exp_q.size()), 32'h0);

        tx_enable = 1'b0;
        drive(1'b0);
        n_acc = 0;
        for (int k = 0; k < 20; k++) drive(1'b1);
        chk("fill_count", 32'(n_acc), 32'd16);
        chk("fill_tready", 32'(s_axis_tready), 32'h0);
        chk("fill_zero", 32'({tx_d_pos, tx_d_neg}), 32'h0);
        chk("fill_idle", 32'(tx_active), 32'h0);

        tx_enable = 1'b1;
        wait_active(1'b1, 5, "full_run");
        drive(1'b0);
        drive(1'b0);
        #2 tx_resetn = 1'b0;
        #1;
        chk("arst_d", 32'({tx_d_pos, tx_d_neg}), 32'h0);
        chk("arst_tready", 32'(s_axis_tready), 32'h0);
        chk("arst_active", 32'(tx_active), 32'h0);
        chk("arst_uf", 32'(underflow_cnt), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge tx_clk_in);
        tx_resetn = 1'b1;
        drive(1'b0);
        chk("rel_tready", 32'(s_axis_tready), 32'h1);
        for (int k = 0; k < 15; k++) drive(1'b0);
        chk("rel_fifo_empty", 32'(tx_active), 32'h0);
        chk("rel_zero", 32'({tx_d_pos, tx_d_neg}), 32'h0);

        mon_en = 1'b0;
        tx_enable = 1'b0;
        drive(1'b0);
        drive(1'b1, 1'b1, {16'h1000, 16'hE000});
        for (int k = 0; k < 7; k++) drive(1'b1);
        tx_enable = 1'b1;
        wait_active(1'b1, 5, "conv_run");
        drive(1'b0);
        chk("conv_pos", 32'(tx_d_pos), 32'(exp12(16'h1000)));
        chk("conv_neg", 32'(tx_d_neg), 32'(exp12(16'hE000)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
